// File: rtl/de10boy_pkg.sv
// Shared constants and types for the CPU/OAM-DMA memory-map arbitration.
package de10boy_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] HRAM_LAST    = 16'hFFFE;
  localparam int          DMA_LEN      = 160;
  localparam int          HRAM_DEPTH   = 127;
  localparam int          DATA_W       = 8;

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} dma_state_t;
  typedef enum logic [1:0] {MEM, HRAM, DMAREG, BLOCKED} rd_sel_t;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
  endfunction

endpackage

// File: rtl/oam_dma_controller_hram.sv
// High RAM (FF80-FFFE): 127 bytes, synchronous write, registered read.
module hram
  import de10boy_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [6:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wren,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:HRAM_DEPTH-1];

  always_ff @(posedge clock) begin
    if (wren) mem[addr] <= wdata;
  end

  // Index 127 (FFFF) is not backed; the read register simply holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (addr < 7'(HRAM_DEPTH)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// Arbitrates the memory-map port between the CPU and the OAM DMA engine.
module oam_dma_controller
  import de10boy_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wren,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wren,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

  dma_state_t state, state_next;
  rd_sel_t    rd_sel;
  logic [7:0] idx, idx_next;
  logic [7:0] dma_reg;
  logic [7:0] hram_rdata;
  logic       cpu_hram;
  logic       dma_start;

  assign cpu_hram   = is_hram(cpu_addr);
  assign dma_start  = cpu_wren && (cpu_addr == DMA_REG_ADDR);
  assign dma_active = (state != IDLE);

  hram u_hram (
    .clock (clock),
    .reset (reset),
    .addr  (cpu_addr[6:0]),
    .wdata (cpu_wdata),
    .wren  (cpu_wren && cpu_hram),
    .rdata (hram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      dma_reg <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (dma_start) dma_reg <= cpu_wdata;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_wren   = 1'b0;
    unique case (state)
      IDLE: begin
        mem_wren = cpu_wren && !cpu_hram && (cpu_addr != DMA_REG_ADDR);
      end
      START: begin
        state_next = READ;
      end
      READ: begin
        mem_addr   = {dma_reg, idx};
        state_next = WRITE;
      end
      WRITE: begin
        // Memory returns the READ-cycle byte now, so it goes straight to OAM.
        mem_addr  = OAM_BASE + {8'h00, idx};
        mem_wdata = mem_rdata;
        mem_wren  = 1'b1;
        if (idx < IDX_LAST) begin
          idx_next   = idx + 8'd1;
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A register write restarts the copy from any state.
    if (dma_start) begin
      state_next = START;
      idx_next   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_sel <= MEM;
    end else if (cpu_hram) begin
      rd_sel <= HRAM;
    end else if (cpu_addr == DMA_REG_ADDR) begin
      rd_sel <= DMAREG;
    end else if (dma_active) begin
      rd_sel <= BLOCKED;
    end else begin
      rd_sel <= MEM;
    end
  end

  always_comb begin
    cpu_rdata = mem_rdata;
    unique case (rd_sel)
      HRAM:    cpu_rdata = hram_rdata;
      DMAREG:  cpu_rdata = dma_reg;
      BLOCKED: cpu_rdata = 8'hFF;
      default: cpu_rdata = mem_rdata;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed/randomized bench for oam_dma_controller with a behavioural memory map.
module tb_oam_dma_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wren;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wren;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] exp_oam [0:159];
  int act_cnt = 0, dma_wr_cnt = 0, idle_wr_cnt = 0;

  always #5 clock = ~clock;

  oam_dma_controller dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wren   (cpu_wren),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  // Memory map: registered read, synchronous write.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clock) begin
    if (dma_active) act_cnt++;
    if (dma_active && mem_wren) dma_wr_cnt++;
    if (!dma_active && mem_wren) idle_wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fill_page(input logic [7:0] page, input bit pattern);
    for (int i = 0; i < 256; i++)
      mem[{page, 8'(i)}] = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
  endtask

  task automatic snap(input logic [7:0] page);
    for (int i = 0; i < 160; i++) exp_oam[i] = mem[{page, 8'(i)}];
  endtask

  function automatic int oam_bad();
    int b = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) b++;
    return b;
  endfunction

  task automatic clear_oam(input logic [7:0] v);
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = v;
  endtask

  // Drive an FF46 write; returns just after the edge that samples it.
  task automatic start_dma(input logic [7:0] page);
    cpu_addr  = 16'hFF46;
    cpu_wdata = page;
    cpu_wren  = 1'b1;
    settle();
    check("ff46_not_forwarded", mem_wren, 1'b0);
    cyc();
    cpu_wren = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_active && n < 600) begin
      cyc();
      settle();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 600), 32'd1);
  endtask

  initial begin
    int a0, w0, i0;
    logic [7:0]  pg, hv;
    logic [15:0] ha;

    reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wren = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) cyc();
    settle();
    check("rst_active", dma_active, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_rdata", cpu_rdata, mem_rdata);
    check("rst_addr", mem_addr, cpu_addr);
    reset = 1'b0;
    cyc();

    // Idle pass-through write then read
    i0 = idle_wr_cnt;
    cpu_addr = 16'hC000; cpu_wdata = 8'h3C; cpu_wren = 1'b1;
    settle();
    check("idle_wren", mem_wren, 1'b1);
    cyc(); cpu_wren = 1'b0;
    cyc(); settle();
    check("idle_rdata", cpu_rdata, 8'h3C);
    check("idle_wren_count", idle_wr_cnt - i0, 1);
    check("idle_mem", mem[16'hC000], 8'h3C);

    // Idle HRAM write stays internal
    ha = 16'hFF80 + 16'($urandom_range(0, 126));
    hv = 8'($urandom);
    cpu_addr = ha; cpu_wdata = hv; cpu_wren = 1'b1;
    settle();
    check("hram_not_forwarded", mem_wren, 1'b0);
    cyc(); cpu_wren = 1'b0;
    cyc(); settle();
    check("idle_hram_rd", cpu_rdata, hv);

    // Full copy from C000 with i^5A pattern
    fill_page(8'hC0, 1'b1);
    for (int i = 0; i < 160; i++) exp_oam[i] = 8'(i) ^ 8'h5A;
    clear_oam(8'h00);
    a0 = act_cnt; w0 = dma_wr_cnt;
    start_dma(8'hC0);
    settle();
    check("start_active", dma_active, 1'b1);
    check("start_wren", mem_wren, 1'b0);
    check("start_addr", mem_addr, 16'h0000);
    cyc(); settle();
    check("read0_addr", mem_addr, 16'hC000);
    check("read0_wren", mem_wren, 1'b0);
    cyc(); settle();
    check("write0_addr", mem_addr, 16'hFE00);
    check("write0_wren", mem_wren, 1'b1);
    check("write0_data", mem_wdata, 8'h5A);
    wait_idle("t1");
    check("t1_active_cycles", act_cnt - a0, 321);
    check("t1_write_pulses", dma_wr_cnt - w0, 160);
    check("t1_oam", oam_bad(), 0);

    // CPU activity during a copy from a random page
    pg = 8'hC8 + 8'($urandom_range(0, 7));
    fill_page(pg, 1'b0);
    snap(pg);
    mem[16'hC100] = 8'h77;
    clear_oam(8'h00);
    a0 = act_cnt; w0 = dma_wr_cnt;
    start_dma(pg);
    repeat (5) cyc();
    cpu_addr = 16'hC000;
    cyc(); settle();
    check("blocked_read", cpu_rdata, 8'hFF);
    cpu_addr = 16'hFF46;
    cyc(); settle();
    check("dmareg_read", cpu_rdata, pg);
    cpu_addr = 16'hC100; cpu_wdata = 8'h11; cpu_wren = 1'b1;
    cyc();
    cpu_addr = 16'hFF90; cpu_wdata = 8'hA5;
    cyc(); cpu_wren = 1'b0;
    cyc(); settle();
    check("hram_a5", cpu_rdata, 8'hA5);
    ha = 16'hFF80 + 16'($urandom_range(0, 126));
    hv = 8'($urandom);
    cpu_addr = ha; cpu_wdata = hv; cpu_wren = 1'b1;
    cyc(); cpu_wren = 1'b0;
    cyc(); settle();
    check("hram_rand", cpu_rdata, hv);
    cpu_addr = 16'h0000;
    wait_idle("t2");
    check("dropped_write", mem[16'hC100], 8'h77);
    check("t2_active_cycles", act_cnt - a0, 321);
    check("t2_write_pulses", dma_wr_cnt - w0, 160);
    check("t2_oam", oam_bad(), 0);

    // Restart at idx 50 with a new source page
    fill_page(8'hD0, 1'b0);
    snap(8'hD0);
    a0 = act_cnt; w0 = dma_wr_cnt;
    start_dma(8'hC0);
    repeat (101) cyc();
    settle();
    check("idx50_addr", mem_addr, 16'hC032);
    start_dma(8'hD0);
    settle();
    check("restart_start", mem_addr, 16'h0000);
    cyc(); settle();
    check("restart_read0", mem_addr, 16'hD000);
    wait_idle("t4");
    check("t4_active_cycles", act_cnt - a0, 423);
    check("t4_write_pulses", dma_wr_cnt - w0, 210);
    check("t4_oam", oam_bad(), 0);
    cpu_addr = 16'hFF46;
    cyc(); settle();
    check("t4_dmareg", cpu_rdata, 8'hD0);
    cpu_addr = 16'h0000;

    // Reset at idx 80 aborts the copy
    fill_page(8'hC4, 1'b0);
    snap(8'hC4);
    for (int i = 80; i < 160; i++) exp_oam[i] = 8'hEE;
    clear_oam(8'hEE);
    a0 = act_cnt; w0 = dma_wr_cnt;
    start_dma(8'hC4);
    repeat (161) cyc();
    settle();
    check("idx80_addr", mem_addr, 16'hC450);
    reset = 1'b1;
    settle();
    check("abort_active", dma_active, 1'b0);
    check("abort_wren", mem_wren, 1'b0);
    check("abort_rdata", cpu_rdata, mem_rdata);
    cyc();
    reset = 1'b0;
    cyc(); settle();
    check("post_abort_active", dma_active, 1'b0);
    check("post_abort_addr", mem_addr, cpu_addr);
    check("t5_active_cycles", act_cnt - a0, 161);
    check("t5_write_pulses", dma_wr_cnt - w0, 80);
    check("t5_oam", oam_bad(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
